video_stream_monitor: RTL

Passive end-of-pipe checker for the pixel stream that the game tops drive toward the SDL/VGA output (`sx`, `sy`, `de`, `frame`, 8-bit RGB). It runs at `clk_pix` alongside the display, never back-pressures, and reports per-frame results:

- measured active width and height;
- CRC-16 over active pixels;
- coordinate, line-width and expected-geometry error flags.

It lets simulation and on-board self-test confirm a rendered frame without a frame buffer.

---
 rtl/video_mon_pkg.sv | 29 ++
 rtl/vmon_crc16.sv | 38 +++
 rtl/video_stream_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/video_mon_pkg.sv
// Shared types, CRC constants and the 24-bit-per-step CRC-16/CCITT-FALSE helper
// for the end-of-pipe video stream monitor.
package video_mon_pkg;

    localparam int unsigned CRC_W = 16;
    localparam int unsigned PIX_W = 24;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic {
        SEEK = 1'b0,
        RUN  = 1'b1
    } vmon_state_e;

    // Consume r, g, b (MSB first), one bit per iteration, no reflection.
    function automatic logic [CRC_W-1:0] crc16_step24(input logic [CRC_W-1:0] crc,
                                                       input logic [PIX_W-1:0] pix);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc;
        for (int i = PIX_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ pix[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_W'(0));
        end
        return c;
    endfunction

endpackage

// File: rtl/vmon_crc16.sv
// Running CRC register over active pixels; clr and en together restart the
// CRC with the current pixel already folded in.
module vmon_crc16
    import video_mon_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [PIX_W-1:0] pix_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic [CRC_W-1:0] crc_base;

    always_comb begin
        crc_base = clr_i ? CRC_INIT : crc_q;
        crc_d    = crc_q;
        if (en_i) begin
            crc_d = crc16_step24(crc_base, pix_i);
        end else if (clr_i) begin
            crc_d = CRC_INIT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/video_stream_monitor.sv
// Passive per-frame checker of the display pixel stream: measures active
// geometry, CRCs the active pixels and flags coordinate/width/geometry errors.
module video_stream_monitor
    import video_mon_pkg::*;
#(
    parameter int unsigned CORDW = 16,
    parameter int unsigned CNTW  = 12,
    parameter int unsigned EXP_W = 640,
    parameter int unsigned EXP_H = 480
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic signed [CORDW-1:0] vid_sx,
    input  logic signed [CORDW-1:0] vid_sy,
    input  logic                    vid_de,
    input  logic                    vid_frame,
    input  logic [7:0]              vid_r,
    input  logic [7:0]              vid_g,
    input  logic [7:0]              vid_b,
    output logic                    res_valid,
    output logic [CNTW-1:0]         res_width,
    output logic [CNTW-1:0]         res_height,
    output logic [CRC_W-1:0]        res_crc,
    output logic                    res_err_coord,
    output logic                    res_err_width,
    output logic                    res_err_geom,
    output logic [15:0]             frame_cnt
);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    vmon_state_e state_q, state_d;

    logic            de_q;
    logic [CNTW-1:0] px_cnt_q, px_cnt_d;
    logic [CNTW-1:0] line_cnt_q, line_cnt_d;
    logic [CNTW-1:0] ref_w_q, ref_w_d;
    logic            e_coord_q, e_coord_d;
    logic            e_width_q, e_width_d;

    logic             res_valid_q, res_valid_d;
    logic [CNTW-1:0]  res_width_q, res_width_d;
    logic [CNTW-1:0]  res_height_q, res_height_d;
    logic [CRC_W-1:0] res_crc_q, res_crc_d;
    logic             res_err_coord_q, res_err_coord_d;
    logic             res_err_width_q, res_err_width_d;
    logic             res_err_geom_q, res_err_geom_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic             do_close, ew_cl, pix_act, coord_bad, crc_clr;
    logic [CNTW-1:0]  px_cl, line_cl, ref_cl, px_base, line_base;
    logic [CRC_W-1:0] crc_cur;

    // Close the open line: a falling de, or a frame pulse arriving while de_q is high.
    always_comb begin
        do_close  = (state_q == RUN) && de_q && (vid_frame || !vid_de);
        px_cl     = do_close ? '0 : px_cnt_q;
        line_cl   = do_close ? sat_inc(line_cnt_q) : line_cnt_q;
        ref_cl    = (do_close && line_cnt_q == '0) ? px_cnt_q : ref_w_q;
        ew_cl     = e_width_q || (do_close && line_cnt_q != '0 && px_cnt_q != ref_w_q);
        px_base   = vid_frame ? '0 : px_cl;
        line_base = vid_frame ? '0 : line_cl;
        pix_act   = vid_de && (state_q == RUN || vid_frame);
        coord_bad = (vid_sx != $signed(CORDW'(px_base))) ||
                    (vid_sy != $signed(CORDW'(line_base)));
    end

    always_comb begin
        state_d         = state_q;
        px_cnt_d        = px_cl;
        line_cnt_d      = line_cl;
        ref_w_d         = ref_cl;
        e_coord_d       = e_coord_q;
        e_width_d       = ew_cl;
        crc_clr         = 1'b0;
        res_valid_d     = 1'b0;
        res_width_d     = res_width_q;
        res_height_d    = res_height_q;
        res_crc_d       = res_crc_q;
        res_err_coord_d = res_err_coord_q;
        res_err_width_d = res_err_width_q;
        res_err_geom_d  = res_err_geom_q;
        frame_cnt_d     = frame_cnt_q;

        case (state_q)
            SEEK: begin
                if (vid_frame) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (vid_frame) begin
                    res_valid_d     = 1'b1;
                    res_width_d     = ref_cl;
                    res_height_d    = line_cl;
                    res_crc_d       = crc_cur;
                    res_err_coord_d = e_coord_q;
                    res_err_width_d = ew_cl;
                    res_err_geom_d  = (ref_cl != CNTW'(EXP_W)) || (line_cl != CNTW'(EXP_H));
                    frame_cnt_d     = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = SEEK;
        endcase

        if (vid_frame) begin
            px_cnt_d   = '0;
            line_cnt_d = '0;
            ref_w_d    = '0;
            e_coord_d  = 1'b0;
            e_width_d  = 1'b0;
            crc_clr    = 1'b1;
        end

        // A pixel on the frame-pulse cycle already belongs to the new frame.
        if (pix_act) begin
            px_cnt_d = sat_inc(px_base);
            if (coord_bad) begin
                e_coord_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q         <= SEEK;
            de_q            <= 1'b0;
            px_cnt_q        <= '0;
            line_cnt_q      <= '0;
            ref_w_q         <= '0;
            e_coord_q       <= 1'b0;
            e_width_q       <= 1'b0;
            res_valid_q     <= 1'b0;
            res_width_q     <= '0;
            res_height_q    <= '0;
            res_crc_q       <= '0;
            res_err_coord_q <= 1'b0;
            res_err_width_q <= 1'b0;
            res_err_geom_q  <= 1'b0;
            frame_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            de_q            <= vid_de;
            px_cnt_q        <= px_cnt_d;
            line_cnt_q      <= line_cnt_d;
            ref_w_q         <= ref_w_d;
            e_coord_q       <= e_coord_d;
            e_width_q       <= e_width_d;
            res_valid_q     <= res_valid_d;
            res_width_q     <= res_width_d;
            res_height_q    <= res_height_d;
            res_crc_q       <= res_crc_d;
            res_err_coord_q <= res_err_coord_d;
            res_err_width_q <= res_err_width_d;
            res_err_geom_q  <= res_err_geom_d;
            frame_cnt_q     <= frame_cnt_d;
        end
    end

    vmon_crc16 u_crc (
        .clk_i  (clk_pix),
        .rst_ni (rst_pix_n),
        .clr_i  (crc_clr),
        .en_i   (pix_act),
        .pix_i  ({vid_r, vid_g, vid_b}),
        .crc_o  (crc_cur)
    );

    assign res_valid     = res_valid_q;
    assign res_width     = res_width_q;
    assign res_height    = res_height_q;
    assign res_crc       = res_crc_q;
    assign res_err_coord = res_err_coord_q;
    assign res_err_width = res_err_width_q;
    assign res_err_geom  = res_err_geom_q;
    assign frame_cnt     = frame_cnt_q;

endmodule
